fpga_reset_sequencer: RTL and testbench

- Synthesizable reset/start sequencer for FPGA builds of csp2verilog output.
- Drives a grouped active-low reset vector: RESETS bits released together, then STARTS bits released together, then DELAYS bits released one at a time in ascending order.
- Each phase is timed by a cycle counter. Software or the bench can re-run the whole sequence at any time.

---
 rtl/fpga_reset_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer.sv
// fpga_reset_sequencer
//
// Releases a grouped active-low reset vector in three timed phases:
//   1. the RESETS primary bits together, RESET_CYCLES cycles after reset,
//   2. the STARTS start bits together, START_CYCLES cycles later,
//   3. the DELAYS delayed bits one at a time, DELAY_CYCLES apart, in
//      ascending index order.
// Empty groups (STARTS=0 or DELAYS=0) skip their phase entirely. The
// whole sequence can be restarted at any time with rearm.
//
// Ports:
//   CLK      in   single clock
//   RESET    in   synchronous active-high reset
//   rearm    in   restart the sequence from HOLD
//   pause    in   freezes the phase counter in START_WAIT and DELAY
//   reset_n  out  [RESETS-1:0] reset group, then STARTS start bits,
//                 then DELAYS delayed bits (all active low)
//   done     out  high when every reset_n bit is high
//   state    out  HOLD=0, START_WAIT=1, DELAY=2, DONE=3
//
// Optional build macro: FPGA_RESET_SEQ_REARM_FILTER_EN
//   When defined, rearm goes through a 2-flop synchronizer and must be
//   seen high for 4 consecutive synchronized cycles before the restart
//   takes effect. When undefined, rearm is used directly.

module fpga_reset_sequencer #(
  parameter int RESETS       = 1,
  parameter int STARTS       = 0,
  parameter int DELAYS       = 0,
  parameter int RESET_CYCLES = 10,
  parameter int START_CYCLES = 10,
  parameter int DELAY_CYCLES = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             rearm,
  input  logic                             pause,
  output logic [RESETS+STARTS+DELAYS-1:0] reset_n,
  output logic                             done,
  output logic [1:0]                       state
);

  localparam int TOTAL   = RESETS + STARTS + DELAYS;
  localparam int MAX_RS  = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
  localparam int MAX_CYC = (MAX_RS > DELAY_CYCLES) ? MAX_RS : DELAY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  // dly_idx must be able to hold DELAYS itself (its saturated value).
  localparam int IDX_W   = (DELAYS > 0) ? $clog2(DELAYS + 1) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DELAYS - 1);

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    START_WAIT = 2'd1,
    DELAY      = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Successor states resolved at elaboration so empty groups are skipped.
  localparam state_t AFTER_START = (DELAYS > 0) ? DELAY : DONE;
  localparam state_t AFTER_HOLD  = (STARTS > 0) ? START_WAIT : AFTER_START;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   dly_idx_reg, dly_idx_next;
  logic [TOTAL-1:0]   reset_n_reg, reset_n_next;
  logic               done_reg, done_next;
  logic               rearm_go;

  // Per-bit masks: which bits belong to the reset/start groups, and which
  // delayed bit is addressed by the current dly_idx.
  logic [TOTAL-1:0]   reset_mask;
  logic [TOTAL-1:0]   start_mask;
  logic [TOTAL-1:0]   delay_hit;

  for (genvar gi = 0; gi < TOTAL; gi++) begin : g_mask
    if (gi < RESETS) begin : g_rst
      assign reset_mask[gi] = 1'b1;
      assign start_mask[gi] = 1'b0;
      assign delay_hit[gi]  = 1'b0;
    end else if (gi < RESETS + STARTS) begin : g_start
      assign reset_mask[gi] = 1'b0;
      assign start_mask[gi] = 1'b1;
      assign delay_hit[gi]  = 1'b0;
    end else begin : g_delay
      assign reset_mask[gi] = 1'b0;
      assign start_mask[gi] = 1'b0;
      assign delay_hit[gi]  = (dly_idx_reg == IDX_W'(gi - RESETS - STARTS));
    end
  end

`ifdef FPGA_RESET_SEQ_REARM_FILTER_EN
  // Two-flop synchronizer followed by a saturating run-length counter.
  // The restart fires on the 4th consecutive synchronized-high cycle.
  logic [1:0] rearm_sync_reg;
  logic [1:0] deb_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rearm_sync_reg <= 2'b00;
      deb_cnt_reg    <= 2'd0;
    end else begin
      rearm_sync_reg <= {rearm_sync_reg[0], rearm};
      if (!rearm_sync_reg[1]) begin
        deb_cnt_reg <= 2'd0;
      end else if (deb_cnt_reg != 2'd3) begin
        deb_cnt_reg <= deb_cnt_reg + 2'd1;
      end
    end
  end

  assign rearm_go = rearm_sync_reg[1] && (deb_cnt_reg == 2'd3);
`else
  assign rearm_go = rearm;
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dly_idx_next = dly_idx_reg;
    reset_n_next = reset_n_reg;

    if (rearm_go) begin
      state_next   = HOLD;
      cnt_next     = '0;
      dly_idx_next = '0;
      reset_n_next = '0;
    end else begin
      unique case (state_reg)
        HOLD: begin
          // pause has no effect while holding the primary resets.
          if (cnt_reg == RESET_LAST) begin
            reset_n_next = reset_n_reg | reset_mask;
            cnt_next     = '0;
            state_next   = AFTER_HOLD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        START_WAIT: begin
          if (!pause) begin
            if (cnt_reg == START_LAST) begin
              reset_n_next = reset_n_reg | start_mask;
              cnt_next     = '0;
              state_next   = AFTER_START;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (!pause) begin
            if (cnt_reg == DELAY_LAST) begin
              reset_n_next = reset_n_reg | delay_hit;
              cnt_next     = '0;
              // Final increment lands on DELAYS; it then holds in DONE.
              dly_idx_next = dly_idx_reg + IDX_W'(1);
              if (dly_idx_reg == IDX_LAST) begin
                state_next = DONE;
              end
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = HOLD;
        end
      endcase
    end

    // Registered alongside the final release so done and the last bit rise
    // on the same edge.
    done_next = (state_next == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= HOLD;
      cnt_reg     <= '0;
      dly_idx_reg <= '0;
      reset_n_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dly_idx_reg <= dly_idx_next;
      reset_n_reg <= reset_n_next;
      done_reg    <= done_next;
    end
  end

  assign reset_n = reset_n_reg;
  assign done    = done_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed testbench for fpga_reset_sequencer.
// Instance dut:  RESETS=1 STARTS=2 DELAYS=2, cycles 4/3/2.
// Instance skip: RESETS=1 STARTS=0 DELAYS=0, RESET_CYCLES=1.
// Outputs are sampled 1 ns after each rising edge; inputs are driven at the
// same point so they are stable for the following edge.

module tb_fpga_reset_sequencer;

  logic       CLK;
  logic       RESET;
  logic       rearm;
  logic       pause;
  logic [4:0] rn_a;
  logic       done_a;
  logic [1:0] st_a;
  logic [0:0] rn_b;
  logic       done_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;

  fpga_reset_sequencer #(
    .RESETS(1), .STARTS(2), .DELAYS(2),
    .RESET_CYCLES(4), .START_CYCLES(3), .DELAY_CYCLES(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .rearm(rearm), .pause(pause),
    .reset_n(rn_a), .done(done_a), .state(st_a)
  );

  fpga_reset_sequencer #(
    .RESETS(1), .STARTS(0), .DELAYS(0),
    .RESET_CYCLES(1), .START_CYCLES(10), .DELAY_CYCLES(4)
  ) skip (
    .CLK(CLK), .RESET(RESET), .rearm(rearm), .pause(pause),
    .reset_n(rn_b), .done(done_b), .state(st_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected main-instance outputs for sequence cycle c, given the hand-
  // computed first cycles at which 00001, 00111, 01111 and 11111 appear.
  task automatic expect_seq(input string tag, input int c,
                            input int t1, input int t2, input int t3, input int t4);
    logic [4:0] e_rn;
    logic [1:0] e_st;
    if (c >= t4)      begin e_rn = 5'b11111; e_st = 2'd3; end
    else if (c >= t3) begin e_rn = 5'b01111; e_st = 2'd2; end
    else if (c >= t2) begin e_rn = 5'b00111; e_st = 2'd2; end
    else if (c >= t1) begin e_rn = 5'b00001; e_st = 2'd1; end
    else              begin e_rn = 5'b00000; e_st = 2'd0; end
    chk($sformatf("%s c%0d reset_n", tag, c), 32'(rn_a), 32'(e_rn));
    chk($sformatf("%s c%0d state", tag, c), 32'(st_a), 32'(e_st));
    chk($sformatf("%s c%0d done", tag, c), 32'(done_a), 32'(c >= t4));
  endtask

  task automatic expect_skip(input string tag, input int c);
    chk($sformatf("%s c%0d skip reset_n", tag, c), 32'(rn_b), 32'(c >= 1));
    chk($sformatf("%s c%0d skip state", tag, c), 32'(st_b), (c >= 1) ? 32'd3 : 32'd0);
    chk($sformatf("%s c%0d skip done", tag, c), 32'(done_b), 32'(c >= 1));
  endtask

  initial begin
    RESET = 1'b1;
    rearm = 1'b0;
    pause = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("reset reset_n", 32'(rn_a), 32'd0);
    chk("reset state", 32'(st_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset skip reset_n", 32'(rn_b), 32'd0);
    chk("reset skip done", 32'(done_b), 32'd0);

    // Baseline timing plus group skipping on the second instance
    RESET = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      expect_seq("base", c, 4, 7, 9, 11);
      if (c <= 2) expect_skip("base", c);
      tick();
    end

    // Pause: ignored in HOLD (cycles 1-2), delays START_WAIT (cycles 5-8)
    // and DELAY (cycle 12)
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      expect_seq("pause", c, 4, 11, 14, 16);
      pause = (c == 1 || c == 2 || (c >= 5 && c <= 8) || c == 12);
      tick();
    end
    pause = 1'b0;

`ifndef FPGA_RESET_SEQ_REARM_FILTER_EN
    // Mid-sequence single-cycle rearm in cycle 8
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c < 9) expect_seq("midrearm", c, 4, 7, 9, 11);
      else       expect_seq("midrearm", c - 9, 4, 7, 9, 11);
      rearm = (c == 8);
      tick();
    end
    rearm = 1'b0;

    // Rearm from DONE, then again while in HOLD (cycle 2)
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c < 3) expect_seq("holdrearm", c, 4, 7, 9, 11);
      else       expect_seq("holdrearm", c - 3, 4, 7, 9, 11);
      rearm = (c == 2);
      tick();
    end
    rearm = 1'b0;
    repeat (6) tick();
`else
    // Filtered rearm: pulses of 1..3 cycles in DONE are ignored
    for (int len = 1; len <= 3; len++) begin
      for (int k = 0; k < len + 8; k++) begin
        chk($sformatf("filt len%0d k%0d state", len, k), 32'(st_a), 32'd3);
        chk($sformatf("filt len%0d k%0d done", len, k), 32'(done_a), 32'd1);
        rearm = (k < len);
        tick();
      end
    end
    rearm = 1'b0;

    // A 4-cycle pulse restarts six cycles after it rises
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("filt4 k%0d state", k), 32'(st_a), 32'd3);
      chk($sformatf("filt4 k%0d done", k), 32'(done_a), 32'd1);
      rearm = (k < 4);
      tick();
    end
    rearm = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      expect_seq("filt4", c, 4, 7, 9, 11);
      tick();
    end
`endif

    // Reset precedence: RESET and rearm together in DONE
    chk("prec pre state", 32'(st_a), 32'd3);
    RESET = 1'b1;
    rearm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("prec k%0d reset_n", k), 32'(rn_a), 32'd0);
      chk($sformatf("prec k%0d state", k), 32'(st_a), 32'd0);
      chk($sformatf("prec k%0d done", k), 32'(done_a), 32'd0);
    end
    RESET = 1'b0;
    rearm = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      expect_seq("prec", c, 4, 7, 9, 11);
      if (c <= 1) expect_skip("prec", c);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
